// File: rtl/midi_decoder_if.sv
// MIDI command encoding shared by the decoder and its consumers, plus the
// byte-in / message-out bus between the UART receiver, decoder and voices.
package midi_pkg;
  localparam int MIDI_CMD_SIZE = 3;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_OFF    = 3'd0;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_ON     = 3'd1;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_POLY_AT     = 3'd2;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CTRL_CHANGE = 3'd3;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PROG_CHANGE = 3'd4;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CHAN_AT     = 3'd5;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PITCH_BEND  = 3'd6;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_SYSTEM      = 3'd7;
endpackage

interface midi_decoder_if;
  import midi_pkg::*;
  logic                     rx_rdy;
  logic [7:0]               rx_data;
  logic                     midi_rdy;
  logic [MIDI_CMD_SIZE-1:0] midi_cmd;
  logic [3:0]               midi_ch_sysn;
  logic [6:0]               midi_data0;
  logic [6:0]               midi_data1;

  modport master (output rx_rdy, rx_data,
                  input  midi_rdy, midi_cmd, midi_ch_sysn, midi_data0, midi_data1);
  modport slave  (input  rx_rdy, rx_data,
                  output midi_rdy, midi_cmd, midi_ch_sysn, midi_data0, midi_data1);
endinterface

// File: rtl/midi_decoder.sv
// MIDI byte-stream parser: running status, interleaved real-time bytes and
// SysEx skipping; emits one registered message strobe per completed message.
module midi_decoder #(
  parameter bit VEL0_NOTE_OFF = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  midi_decoder_if.slave   bus
);
  import midi_pkg::*;

  localparam logic [1:0] WAIT_STATUS = 2'd0;
  localparam logic [1:0] WAIT_D0     = 2'd1;
  localparam logic [1:0] WAIT_D1     = 2'd2;
  localparam logic [1:0] SYSEX       = 2'd3;

  logic [1:0]               state_r, state_n_s;
  logic [7:0]               status_r, status_n_s;
  logic [7:0]               run_status_r, run_status_n_s;
  logic                     run_valid_r, run_valid_n_s;
  logic [6:0]               data0_r, data0_n_s;
  logic                     emit_s;
  logic [7:0]               emit_st_s;
  logic [6:0]               emit_d0_s, emit_d1_s;
  logic                     midi_rdy_r;
  logic [MIDI_CMD_SIZE-1:0] midi_cmd_r;
  logic [3:0]               midi_ch_sysn_r;
  logic [6:0]               midi_data0_r, midi_data1_r;

  function automatic logic one_data(input logic [7:0] st);
    one_data = (st[7:4] == 4'hC) || (st[7:4] == 4'hD) || (st == 8'hF1) || (st == 8'hF3);
  endfunction

  // Note-on with zero velocity folds to note-off only in the reported command.
  function automatic logic [MIDI_CMD_SIZE-1:0] cmd_of(input logic [7:0] st, input logic [6:0] d1);
    if (st[7:4] == 4'hF) begin
      cmd_of = MIDI_CMD_SYSTEM;
    end else if (VEL0_NOTE_OFF && (st[7:4] == 4'h9) && (d1 == 7'd0)) begin
      cmd_of = MIDI_CMD_NOTE_OFF;
    end else begin
      cmd_of = st[6:4];
    end
  endfunction

  // Parser next-state and emit decision for the byte presented this cycle.
  always_comb begin
    state_n_s      = state_r;
    status_n_s     = status_r;
    run_status_n_s = run_status_r;
    run_valid_n_s  = run_valid_r;
    data0_n_s      = data0_r;
    emit_s         = 1'b0;
    emit_st_s      = status_r;
    emit_d0_s      = 7'd0;
    emit_d1_s      = 7'd0;
    if (!bus.rx_rdy) begin
      emit_s = 1'b0;
    end else if (bus.rx_data[7:3] == 5'b11111) begin
      // real-time: report and leave every piece of parser state untouched
      emit_s    = 1'b1;
      emit_st_s = bus.rx_data;
    end else if (bus.rx_data[7]) begin
      case (bus.rx_data)
        8'hF0: begin
          state_n_s     = SYSEX;
          run_valid_n_s = 1'b0;
        end
        8'hF4, 8'hF5, 8'hF7: begin
          state_n_s     = WAIT_STATUS;
          run_valid_n_s = 1'b0;
        end
        8'hF6: begin
          state_n_s = WAIT_STATUS;
          emit_s    = 1'b1;
          emit_st_s = bus.rx_data;
        end
        default: begin
          status_n_s = bus.rx_data;
          state_n_s  = WAIT_D0;
          if (bus.rx_data[7:4] != 4'hF) begin
            run_status_n_s = bus.rx_data;
            run_valid_n_s  = 1'b1;
          end else begin
            run_valid_n_s  = run_valid_r;
          end
        end
      endcase
    end else begin
      case (state_r)
        WAIT_STATUS: begin
          if (run_valid_r) begin
            status_n_s = run_status_r;
            data0_n_s  = bus.rx_data[6:0];
            emit_st_s  = run_status_r;
            emit_d0_s  = bus.rx_data[6:0];
            if (one_data(run_status_r)) begin
              emit_s = 1'b1;
            end else begin
              state_n_s = WAIT_D1;
            end
          end else begin
            state_n_s = WAIT_STATUS;
          end
        end
        WAIT_D0: begin
          data0_n_s = bus.rx_data[6:0];
          emit_d0_s = bus.rx_data[6:0];
          if (one_data(status_r)) begin
            emit_s    = 1'b1;
            state_n_s = WAIT_STATUS;
          end else begin
            state_n_s = WAIT_D1;
          end
        end
        WAIT_D1: begin
          emit_s    = 1'b1;
          emit_d0_s = data0_r;
          emit_d1_s = bus.rx_data[6:0];
          state_n_s = WAIT_STATUS;
        end
        SYSEX: begin
          state_n_s = SYSEX;
        end
        default: begin
          state_n_s = WAIT_STATUS;
        end
      endcase
    end
  end

  // Parser state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= WAIT_STATUS;
      status_r     <= 8'd0;
      run_status_r <= 8'd0;
      run_valid_r  <= 1'b0;
      data0_r      <= 7'd0;
    end else begin
      state_r      <= state_n_s;
      status_r     <= status_n_s;
      run_status_r <= run_status_n_s;
      run_valid_r  <= run_valid_n_s;
      data0_r      <= data0_n_s;
    end
  end

  // Output message registers, held between emits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      midi_rdy_r     <= 1'b0;
      midi_cmd_r     <= '0;
      midi_ch_sysn_r <= 4'd0;
      midi_data0_r   <= 7'd0;
      midi_data1_r   <= 7'd0;
    end else begin
      midi_rdy_r <= emit_s;
      if (emit_s) begin
        midi_cmd_r     <= cmd_of(emit_st_s, emit_d1_s);
        midi_ch_sysn_r <= emit_st_s[3:0];
        midi_data0_r   <= emit_d0_s;
        midi_data1_r   <= emit_d1_s;
      end
    end
  end

  assign bus.midi_rdy     = midi_rdy_r;
  assign bus.midi_cmd     = midi_cmd_r;
  assign bus.midi_ch_sysn = midi_ch_sysn_r;
  assign bus.midi_data0   = midi_data0_r;
  assign bus.midi_data1   = midi_data1_r;
endmodule
